servant_ram_loader: RTL and testbench
=====================================

// Module: servant_ram_loader
// PURPOSE
//  Boot loader sitting directly upstream of the servant RAM on its Wishbone port.
//  - Consumes a byte stream from a host link (UART RX or similar).
//  - Packs the bytes little-endian into 32-bit words and writes them to RAM from word 0 upward.
//  - Holds the SERV core in reset until the image is complete, then releases it.
//  - Muxed ahead of the CPU data/instruction arbiter; owns the RAM port while o_cpu_rst=1.
// PARAMETERS
//  depth   256   RAM size in bytes; must match the RAM instance; max words = depth/4
//  aw      $clog2(depth)   byte-address width; o_wb_adr[aw-1:2] significant, upper bits 0
// PORTS
//  i_wb_clk    in   1    clock
//  i_wb_rst    in   1    synchronous, active-high reset
//  i_rx_data   in   8    incoming byte
//  i_rx_valid  in   1    i_rx_data valid
//  o_rx_ready  out  1    byte accepted when i_rx_valid & o_rx_ready
//  o_wb_adr    out  30   word address [31:2]
//  o_wb_dat    out  32   write data
//  o_wb_sel    out  4    always 4'hF
//  o_wb_we     out  1    always 1 while o_wb_cyc
//  o_wb_cyc    out  1    cycle request
//  i_wb_ack    in   1    RAM acknowledge
//  o_cpu_rst   out  1    1 = hold core in reset
//  o_done      out  1    image loaded, core released
//  o_error     out  1    load aborted; sticky until reset
// BEHAVIOUR
//  Reset values: o_rx_ready=0, o_wb_cyc=0, o_wb_adr=0, o_wb_dat=0, o_cpu_rst=1, o_done=0, o_error=0.
//  Stream format: LEN_LO, LEN_HI (16-bit word count N), then 4*N data bytes, LSB first.
//  FSM (registered outputs):
//   - HDR0: ready=1; on accept latch LEN_LO -> HDR1.
//   - HDR1: ready=1; on accept latch LEN_HI.
//       N > depth/4 -> ERR; N == 0 -> CHK (if checksum enabled) else DONE; otherwise -> DATA.
//   - DATA: ready=1; shift byte into byte lane k (k = 0..3).
//       On 4th accept -> WRITE, with o_wb_dat = packed word, o_wb_adr = word index.
//   - WRITE: ready=0, cyc=1. On i_wb_ack, cyc drops the next cycle (never held across ack:
//       the RAM re-acks a held cyc). Index increments; index == N -> CHK/DONE, else DATA.
//   - CHK: see CONFIGURATION.
//   - DONE: o_cpu_rst=0, o_done=1, ready=0; terminal until reset.
//   - ERR: o_error=1, o_cpu_rst=1, ready=0; terminal until reset.
//  Timing and boundaries:
//   - Per-word cost: 4 accept cycles + 2 cycles ready=0 (cyc, ack).
//   - Back-to-back valid gives 1 byte/cycle otherwise.
//   - Word index is aw-2 bits; no wrap is possible because N is bounded at the header.
//   - N == depth/4 is legal; the last word goes to address depth/4-1.
//   - i_rx_valid while ready=0: byte not consumed; the source holds it.
//   - Reset mid-WRITE or mid-word: cyc drops, partial word discarded, back to HDR0 with core held.
//   - o_cpu_rst deasserts in the same cycle o_done rises, never earlier than the final ack + 1.
// CONFIGURATION
//  Macro SERVANT_LOADER_CHECKSUM_EN:
//   - Defined: one trailing byte after the data, equal to the XOR of all 4*N data bytes
//     (header excluded). CHK state: ready=1; on accept, match -> DONE, mismatch -> ERR.
//     For N=0 the expected value is 8'h00.
//   - Undefined: CHK state and the XOR register are absent; the last ack goes -> DONE.
//     o_error is driven only by the length check.
// STRUCTURE
//  Package servant_loader_pkg:
//   - state encoding localparams HDR0/HDR1/DATA/WRITE/CHK/DONE/ERR (3 bits)
//   - LEN_BYTES=2
//   - SEL_ALL=4'hF
//  One sub-module: servant_loader_wordpack.
//   - Function: byte -> 32-bit little-endian shift/pack register with 2-bit lane counter.
//   - Ports: i_clk, i_rst, i_clr, i_en, i_byte, o_word, o_full.
//  Top holds the FSM, word index, length register and optional XOR.
// TESTING
//  Bench pairs the loader with a servant RAM model (1-cycle ack), depth=256.
//  1. Stream 02 00 | 78 56 34 12 | EF BE AD DE -> mem[0]=32'h12345678, mem[1]=32'hDEADBEEF;
//     o_done=1, o_cpu_rst=0, exactly 2 cyc pulses each 1 cycle after the 4th byte.
//  2. Header 00 00 -> DONE with zero Wishbone cycles (checksum on: send 00 -> DONE; send 01 -> ERR).
//  3. Header 41 00 (65 > 64 words) -> o_error=1 next cycle, o_rx_ready=0, no writes, o_cpu_rst=1.
//  4. Header 40 00 with 256 bytes -> mem[63] written last, index never wraps to mem[0] again.
//  5. Random i_rx_valid gaps and valid held during WRITE -> no byte lost or duplicated;
//     cyc never high on the cycle after ack.
//  6. Assert i_wb_rst during the 2nd word's WRITE -> cyc=0 next cycle, outputs at reset values;
//     a fresh full stream then loads correctly.

Source files
------------

// File: rtl/servant_loader_pkg.sv
// Shared definitions for the servant RAM boot loader: FSM state encoding,
// header length and the fixed Wishbone byte-select value.
package servant_loader_pkg;

    // Loader FSM states (3-bit encoding)
    typedef enum logic [2:0] {
        HDR0  = 3'd0,
        HDR1  = 3'd1,
        DATA  = 3'd2,
        WRITE = 3'd3,
        CHK   = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_t;

    // The header is a 16-bit little-endian word count
    localparam int LEN_BYTES = 2;

    // Every RAM write is a full 32-bit word
    localparam logic [3:0] SEL_ALL = 4'hF;

endpackage

// File: rtl/servant_loader_wordpack.sv
// Byte-to-word packer: bytes arrive LSB first and are shifted in from the top,
// so after four enables byte 0 sits in [7:0] and byte 3 in [31:24].
// o_full flags that the lane counter is on the last lane, i.e. the next
// enabled byte completes the word.
module servant_loader_wordpack (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_word,
    output logic        o_full
);

    logic [31:0] word_q, word_d;
    logic [1:0]  lane_q, lane_d;

    // Shift the incoming byte into the top lane and advance the lane counter
    always_comb begin
        word_d = word_q;
        lane_d = lane_q;
        if (i_clr) begin
            word_d = 32'h0;
            lane_d = 2'd0;
        end else if (i_en) begin
            word_d = {i_byte, word_q[31:8]};
            lane_d = lane_q + 2'd1;
        end
    end

    // Packing registers; reset discards any partial word
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            word_q <= 32'h0;
            lane_q <= 2'd0;
        end else begin
            word_q <= word_d;
            lane_q <= lane_d;
        end
    end

    assign o_word = word_q;
    assign o_full = (lane_q == 2'd3);

endmodule

// File: rtl/servant_ram_loader.sv
// Boot loader in front of the servant RAM Wishbone port. Receives a byte
// stream (16-bit word count, then 4*N data bytes LSB first), writes the packed
// words from address 0 upward and keeps the SERV core in reset until the image
// is complete.
// Optional feature: define SERVANT_LOADER_CHECKSUM_EN to require one trailing
// byte equal to the XOR of all data bytes; a mismatch ends in the error state.
module servant_ram_loader
    import servant_loader_pkg::*;
#(
    parameter int depth = 256,
    parameter int aw    = $clog2(depth)
) (
    input  logic        i_wb_clk,
    input  logic        i_wb_rst,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_valid,
    output logic        o_rx_ready,
    output logic [29:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic        i_wb_ack,
    output logic        o_cpu_rst,
    output logic        o_done,
    output logic        o_error
);

    localparam int         IW        = aw - 2;
    localparam int         HDR_BITS  = 8 * LEN_BYTES;
    localparam logic [16:0] MAX_WORDS = 17'(depth / 4);

`ifdef SERVANT_LOADER_CHECKSUM_EN
    localparam state_t TAIL = CHK;
`else
    localparam state_t TAIL = DONE;
`endif

    state_t          state_q, state_d;
    logic [7:0]      len_lo_q, len_lo_d;
    logic [15:0]     len_q, len_d;
    logic [IW-1:0]   index_q, index_d;
    logic            rx_ready_q, rx_ready_d;
    logic            cyc_q, cyc_d;
    logic            cpu_rst_q, cpu_rst_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
`ifdef SERVANT_LOADER_CHECKSUM_EN
    logic [7:0]      xor_q, xor_d;
`endif

    logic                accept;
    logic                ack;
    logic                last_word;
    logic [HDR_BITS-1:0] hdr_len;
    logic                pack_en;
    logic                pack_clr;
    logic                pack_full;
    logic [31:0]         pack_word;

    assign accept    = i_rx_valid & rx_ready_q;
    assign ack       = i_wb_ack & cyc_q;
    assign hdr_len   = {i_rx_data, len_lo_q};
    assign last_word = (({{(17-IW){1'b0}}, index_q} + 17'd1) == {1'b0, len_q});
    assign pack_en   = (state_q == DATA) && accept;
    assign pack_clr  = (state_q == HDR1) && accept;

    servant_loader_wordpack u_wordpack (
        .i_clk  (i_wb_clk),
        .i_rst  (i_wb_rst),
        .i_clr  (pack_clr),
        .i_en   (pack_en),
        .i_byte (i_rx_data),
        .o_word (pack_word),
        .o_full (pack_full)
    );

    // State and registered outputs; reset drops cyc and holds the core
    always_ff @(posedge i_wb_clk) begin
        if (i_wb_rst) begin
            state_q    <= HDR0;
            len_lo_q   <= 8'h0;
            len_q      <= 16'h0;
            index_q    <= '0;
            rx_ready_q <= 1'b0;
            cyc_q      <= 1'b0;
            cpu_rst_q  <= 1'b1;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
`ifdef SERVANT_LOADER_CHECKSUM_EN
            xor_q      <= 8'h0;
`endif
        end else begin
            state_q    <= state_d;
            len_lo_q   <= len_lo_d;
            len_q      <= len_d;
            index_q    <= index_d;
            rx_ready_q <= rx_ready_d;
            cyc_q      <= cyc_d;
            cpu_rst_q  <= cpu_rst_d;
            done_q     <= done_d;
            error_q    <= error_d;
`ifdef SERVANT_LOADER_CHECKSUM_EN
            xor_q      <= xor_d;
`endif
        end
    end

    // Next-state: header parse, byte collection, one write per word, finish
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            HDR0: if (accept) state_d = HDR1;
            HDR1: begin
                if (accept) begin
                    if ({1'b0, hdr_len} > MAX_WORDS) begin
                        state_d = ERR;
                    end else if (hdr_len == '0) begin
                        state_d = TAIL;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA:  if (accept && pack_full) state_d = WRITE;
            WRITE: if (ack) state_d = last_word ? TAIL : DATA;
`ifdef SERVANT_LOADER_CHECKSUM_EN
            CHK:   if (accept) state_d = (i_rx_data == xor_q) ? DONE : ERR;
`endif
            DONE:  state_d = DONE;
            ERR:   state_d = ERR;
            default: state_d = HDR0;
        endcase
    end

    // Datapath: length capture, word index and running checksum
    always_comb begin
        len_lo_d = len_lo_q;
        len_d    = len_q;
        index_d  = index_q;
`ifdef SERVANT_LOADER_CHECKSUM_EN
        xor_d    = xor_q;
        if (pack_clr) xor_d = 8'h0;
        else if (pack_en) xor_d = xor_q ^ i_rx_data;
`endif
        if ((state_q == HDR0) && accept) len_lo_d = i_rx_data;
        if (pack_clr) begin
            len_d   = hdr_len;
            index_d = '0;
        end
        if ((state_q == WRITE) && ack && !last_word) index_d = index_q + 1'b1;
    end

    // Outputs follow the state being entered so they are registered with it
    always_comb begin
        rx_ready_d = (state_d == HDR0) || (state_d == HDR1) ||
                     (state_d == DATA) || (state_d == CHK);
        cyc_d      = (state_d == WRITE);
        cpu_rst_d  = (state_d != DONE);
        done_d     = (state_d == DONE);
        error_d    = (state_d == ERR);
    end

    assign o_rx_ready = rx_ready_q;
    assign o_wb_adr   = {{(30-IW){1'b0}}, index_q};
    assign o_wb_dat   = pack_word;
    assign o_wb_sel   = SEL_ALL;
    assign o_wb_we    = cyc_q;
    assign o_wb_cyc   = cyc_q;
    assign o_cpu_rst  = cpu_rst_q;
    assign o_done     = done_q;
    assign o_error    = error_q;

endmodule

// File: tb/tb_servant_ram_loader.sv
// Testbench for servant_ram_loader paired with a 1-cycle-ack RAM model
// (depth 256 bytes = 64 words). Directed streams with hand-computed words.
module tb_servant_ram_loader;

   logic        clk;
   logic        rst;
   logic [7:0]  rxData;
   logic        rxValid;
   logic        rxReady;
   logic [29:0] wbAdr;
   logic [31:0] wbDat;
   logic [3:0]  wbSel;
   logic        wbWe;
   logic        wbCyc;
   logic        wbAck;
   logic        cpuRst;
   logic        done;
   logic        error;

   int compared   = 0;
   int mismatched = 0;

   logic [31:0] mem [0:63];
   int          cycleCount = 0;
   int          writes, cycPulses, cycAfterAck, badTiming, badSel, badAdr;
   int          releaseMismatch, lastAcceptCycle, lastAckCycle, doneCycle;
   logic [29:0] lastAdr;
   logic        prevCyc, prevAck, prevDone;

   logic [7:0]  streamQ [$];
   logic [7:0]  xorAcc;

   servant_ram_loader #(.depth(256)) dut (
      .i_wb_clk   (clk),
      .i_wb_rst   (rst),
      .i_rx_data  (rxData),
      .i_rx_valid (rxValid),
      .o_rx_ready (rxReady),
      .o_wb_adr   (wbAdr),
      .o_wb_dat   (wbDat),
      .o_wb_sel   (wbSel),
      .o_wb_we    (wbWe),
      .o_wb_cyc   (wbCyc),
      .i_wb_ack   (wbAck),
      .o_cpu_rst  (cpuRst),
      .o_done     (done),
      .o_error    (error)
   );

   // Free-running clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM model with 1-cycle ack plus protocol monitors
   always @(posedge clk) begin
      cycleCount <= cycleCount + 1;
      if (rst) begin
         wbAck           <= 1'b0;
         writes          <= 0;
         cycPulses       <= 0;
         cycAfterAck     <= 0;
         badTiming       <= 0;
         badSel          <= 0;
         badAdr          <= 0;
         releaseMismatch <= 0;
         lastAcceptCycle <= 0;
         lastAckCycle    <= 0;
         doneCycle       <= 0;
         lastAdr         <= '0;
         prevCyc         <= 1'b0;
         prevAck         <= 1'b0;
         prevDone        <= 1'b0;
         for (int i = 0; i < 64; i++) mem[i] <= 32'hA5A5A5A5;
      end else begin
         prevCyc  <= wbCyc;
         prevAck  <= wbAck;
         prevDone <= done;
         if (wbCyc && !wbAck) begin
            if (wbAdr < 30'd64) mem[wbAdr[5:0]] <= wbDat;
            else badAdr <= badAdr + 1;
            wbAck   <= 1'b1;
            writes  <= writes + 1;
            lastAdr <= wbAdr;
            if (wbSel != 4'hF || !wbWe) badSel <= badSel + 1;
         end else begin
            wbAck <= 1'b0;
         end
         if (wbCyc && wbAck) lastAckCycle <= cycleCount;
         if (prevAck && wbCyc) cycAfterAck <= cycAfterAck + 1;
         if (wbCyc && !prevCyc) begin
            cycPulses <= cycPulses + 1;
            if (cycleCount != lastAcceptCycle + 1) badTiming <= badTiming + 1;
         end
         if (rxValid && rxReady) lastAcceptCycle <= cycleCount;
         if (cpuRst == done) releaseMismatch <= releaseMismatch + 1;
         if (done && !prevDone) doneCycle <= cycleCount;
      end
   end

   // Single comparison point: counts and reports every check
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      if (observed !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
      end
   endtask

   // Present one byte after an idle gap and hold it until accepted
   task automatic applyStimulus(input logic [7:0] b, input int gap);
      bit taken;
      int waitCycles;
      rxValid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(posedge clk);
         #1;
      end
      rxValid    = 1'b1;
      rxData     = b;
      taken      = 1'b0;
      waitCycles = 0;
      while (!taken && waitCycles < 200) begin
         @(negedge clk);
         if (rxReady) taken = 1'b1;
         @(posedge clk);
         #1;
         waitCycles++;
      end
      rxValid = 1'b0;
      if (!taken) checkOutput("rx_accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic beginStream(input logic [15:0] n);
      streamQ.delete();
      streamQ.push_back(n[7:0]);
      streamQ.push_back(n[15:8]);
      xorAcc = 8'h00;
   endtask

   task automatic addWord(input logic [31:0] w);
      for (int k = 0; k < 4; k++) begin
         streamQ.push_back(w[8*k +: 8]);
         xorAcc = xorAcc ^ w[8*k +: 8];
      end
   endtask

   task automatic sendStream(input int maxGap, input bit withChecksum);
      foreach (streamQ[i]) applyStimulus(streamQ[i], $urandom_range(0, maxGap));
`ifdef SERVANT_LOADER_CHECKSUM_EN
      if (withChecksum) applyStimulus(xorAcc, 0);
`else
      if (withChecksum) rxValid = 1'b0;
`endif
   endtask

   task automatic waitDone();
      int n;
      n = 0;
      while (!(done || error) && n < 300) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      if (!(done || error)) checkOutput("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic doReset();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   function automatic logic [31:0] rampWord(input int w);
      logic [7:0] b0, b1, b2, b3;
      b0 = 8'(4*w);
      b1 = 8'(4*w + 1);
      b2 = 8'(4*w + 2);
      b3 = 8'(4*w + 3);
      return {b3, b2, b1, b0};
   endfunction

   initial begin
      rst     = 1'b1;
      rxValid = 1'b0;
      rxData  = 8'h00;
      @(posedge clk);
      @(posedge clk);
      #1;
      checkOutput("rst_ready",  {31'd0, rxReady}, 32'd0);
      checkOutput("rst_cyc",    {31'd0, wbCyc},   32'd0);
      checkOutput("rst_adr",    {2'd0, wbAdr},    32'd0);
      checkOutput("rst_dat",    wbDat,            32'd0);
      checkOutput("rst_cpurst", {31'd0, cpuRst},  32'd1);
      checkOutput("rst_done",   {31'd0, done},    32'd0);
      checkOutput("rst_error",  {31'd0, error},   32'd0);
      rst = 1'b0;

      // Two-word image, back-to-back bytes
      beginStream(16'd2);
      addWord(32'h12345678);
      addWord(32'hDEADBEEF);
      sendStream(0, 1'b1);
      waitDone();
      checkOutput("t1_mem0",     mem[0],          32'h12345678);
      checkOutput("t1_mem1",     mem[1],          32'hDEADBEEF);
      checkOutput("t1_done",     {31'd0, done},   32'd1);
      checkOutput("t1_cpurst",   {31'd0, cpuRst}, 32'd0);
      checkOutput("t1_error",    {31'd0, error},  32'd0);
      checkOutput("t1_cycpulse", cycPulses,       32'd2);
      checkOutput("t1_cyctime",  badTiming,       32'd0);
      checkOutput("t1_sel_we",   badSel,          32'd0);
      checkOutput("t1_cycack",   cycAfterAck,     32'd0);
      checkOutput("t1_release",  releaseMismatch, 32'd0);
      checkOutput("t1_afterack", {31'd0, (doneCycle > lastAckCycle)}, 32'd1);

      // Empty image
      doReset();
      beginStream(16'd0);
      sendStream(0, 1'b1);
      waitDone();
      checkOutput("t2_done",   {31'd0, done},   32'd1);
      checkOutput("t2_cpurst", {31'd0, cpuRst}, 32'd0);
      checkOutput("t2_writes", writes,          32'd0);
`ifdef SERVANT_LOADER_CHECKSUM_EN
      doReset();
      applyStimulus(8'h00, 0);
      applyStimulus(8'h00, 0);
      applyStimulus(8'h01, 0);
      waitDone();
      checkOutput("t2_badchk_err",  {31'd0, error}, 32'd1);
      checkOutput("t2_badchk_done", {31'd0, done},  32'd0);
`endif

      // Oversized length: 65 words
      doReset();
      applyStimulus(8'h41, 0);
      applyStimulus(8'h00, 0);
      checkOutput("t3_error",  {31'd0, error},   32'd1);
      checkOutput("t3_ready",  {31'd0, rxReady}, 32'd0);
      checkOutput("t3_cpurst", {31'd0, cpuRst},  32'd1);
      rxValid = 1'b1;
      rxData  = 8'h55;
      repeat (5) @(posedge clk);
      #1;
      rxValid = 1'b0;
      checkOutput("t3_ready_hold", {31'd0, rxReady}, 32'd0);
      checkOutput("t3_writes",     writes,           32'd0);
      checkOutput("t3_sticky",     {31'd0, error},   32'd1);

      // Full RAM: 64 words
      doReset();
      beginStream(16'd64);
      for (int w = 0; w < 64; w++) addWord(rampWord(w));
      sendStream(0, 1'b1);
      waitDone();
      checkOutput("t4_mem0",    mem[0],         32'h03020100);
      checkOutput("t4_mem31",   mem[31],        32'h7F7E7D7C);
      checkOutput("t4_mem63",   mem[63],        32'hFFFEFDFC);
      checkOutput("t4_writes",  writes,         32'd64);
      checkOutput("t4_lastadr", {2'd0, lastAdr}, 32'd63);
      checkOutput("t4_badadr",  badAdr,         32'd0);
      checkOutput("t4_done",    {31'd0, done},  32'd1);

      // Random gaps, valid held across WRITE
      doReset();
      beginStream(16'd3);
      addWord(32'hCAFEF00D);
      addWord(32'h01020304);
      addWord(32'h80FF7F00);
      sendStream(3, 1'b1);
      waitDone();
      checkOutput("t5_mem0",   mem[0],        32'hCAFEF00D);
      checkOutput("t5_mem1",   mem[1],        32'h01020304);
      checkOutput("t5_mem2",   mem[2],        32'h80FF7F00);
      checkOutput("t5_writes", writes,        32'd3);
      checkOutput("t5_cycack", cycAfterAck,   32'd0);
      checkOutput("t5_done",   {31'd0, done}, 32'd1);

      // Reset during the second word's write, then a fresh load
      doReset();
      beginStream(16'd2);
      addWord(32'h11223344);
      addWord(32'h55667788);
      sendStream(0, 1'b0);
      checkOutput("t6_in_write", {31'd0, wbCyc}, 32'd1);
      checkOutput("t6_adr1",     {2'd0, wbAdr},  32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("t6_cyc",    {31'd0, wbCyc},   32'd0);
      checkOutput("t6_ready",  {31'd0, rxReady}, 32'd0);
      checkOutput("t6_cpurst", {31'd0, cpuRst},  32'd1);
      checkOutput("t6_adr",    {2'd0, wbAdr},    32'd0);
      checkOutput("t6_dat",    wbDat,            32'd0);
      checkOutput("t6_done",   {31'd0, done},    32'd0);
      @(posedge clk);
      #1 rst = 1'b0;
      beginStream(16'd2);
      addWord(32'hA0B1C2D3);
      addWord(32'h0F1E2D3C);
      sendStream(1, 1'b1);
      waitDone();
      checkOutput("t6_mem0",   mem[0],        32'hA0B1C2D3);
      checkOutput("t6_mem1",   mem[1],        32'h0F1E2D3C);
      checkOutput("t6_writes", writes,        32'd2);
      checkOutput("t6_done2",  {31'd0, done}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
